// File: rtl/usb_tx_pkg.sv
// Shared encodings for the USB TX packet controller: request types, FSM states,
// PID bytes and CRC16 constants.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_ACK   = 3'd1,
        PKT_NAK   = 3'd2,
        PKT_STALL = 3'd3,
        PKT_DATA0 = 3'd4,
        PKT_DATA1 = 3'd5
    } tx_pkt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_ERR
    } tx_state_e;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    function automatic logic is_data_pkt(input tx_pkt_e pkt);
        return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
    endfunction

    function automatic logic [7:0] pid_of(input tx_pkt_e pkt);
        case (pkt)
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC-16/USB step: folds one byte, LSB first, into the running CRC.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] crc_acc;

    // NOTE: blocking assignments here are deliberate: each loop iteration must see
    // the value produced by the previous one, which is how an unrolled XOR chain is built.
    always_comb begin
        crc_acc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_acc[0] ^ data[i]) begin
                crc_acc = (crc_acc >> 1) ^ CRC16_POLY_R;
            end else begin
                crc_acc = crc_acc >> 1;
            end
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// Byte-level USB TX packet sequencer: SYNC, PID, optional payload + CRC16, EOP,
// with payload length/underrun checking and packet abort.
module usb_tx_pkt_ctrl
    import usb_tx_pkg::*;
#(
    parameter int          MAX_PAYLOAD = 64,
    parameter int          OCC_W       = $clog2(MAX_PAYLOAD + 1),
    parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       tx_packet,
    input  logic [OCC_W-1:0] buff_occ,
    input  logic [7:0]       tx_data,
    output logic             get_tx_data,
    output logic [7:0]       tx_byte,
    output logic             tx_byte_valid,
    input  logic             tx_byte_ready,
    output logic             tx_eop,
    input  logic             tx_eop_done,
    output logic             tx_abort,
    output logic             TX_Transfer_Active,
    output logic             TX_Error
);

    localparam logic [OCC_W:0] MAX_LEN = (OCC_W + 1)'(MAX_PAYLOAD);

    tx_state_e        state_q, state_d;
    tx_pkt_e          type_q, type_d;
    logic [OCC_W-1:0] len_q, len_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [15:0]      crc_next;

    logic req_data;
    logic xfer;

    assign req_data = (tx_packet == 3'd4) || (tx_packet == 3'd5);
    assign xfer     = tx_byte_valid && tx_byte_ready;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data    (tx_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= PKT_NONE;
            len_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= CRC16_INIT;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
        end
    end

    // NOTE: every output and next-state signal gets a default before the case so
    // that no path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d            = state_q;
        type_d             = type_q;
        len_d              = len_q;
        cnt_d              = cnt_q;
        crc_d              = crc_q;
        tx_byte            = 8'h00;
        tx_byte_valid      = 1'b0;
        get_tx_data        = 1'b0;
        tx_eop             = 1'b0;
        tx_abort           = 1'b0;
        TX_Error           = 1'b0;
        TX_Transfer_Active = (state_q != ST_IDLE) && (state_q != ST_ERR);

        case (state_q)
            ST_IDLE: begin
                if (tx_packet > 3'd5) begin
                    state_d = ST_ERR;
                end else if (tx_packet != 3'd0) begin
                    if (req_data && ({1'b0, buff_occ} > MAX_LEN)) begin
                        state_d = ST_ERR;
                    end else begin
                        type_d  = tx_pkt_e'(tx_packet);
                        len_d   = req_data ? buff_occ : '0;
                        cnt_d   = '0;
                        crc_d   = CRC16_INIT;
                        state_d = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                tx_byte       = SYNC_BYTE;
                tx_byte_valid = 1'b1;
                if (xfer) state_d = ST_PID;
            end
            ST_PID: begin
                tx_byte       = pid_of(type_q);
                tx_byte_valid = 1'b1;
                if (xfer) begin
                    if (!is_data_pkt(type_q)) state_d = ST_EOP;
                    else if (len_q != '0)     state_d = ST_DATA;
                    else                      state_d = ST_CRC_LO;
                end
            end
            ST_DATA: begin
                tx_byte       = tx_data;
                tx_byte_valid = (buff_occ != '0);
                // Only entered while bytes remain, so an empty FIFO here is an underrun.
                if (buff_occ == '0) begin
                    state_d = ST_ERR;
                end else if (tx_byte_ready) begin
                    get_tx_data = 1'b1;
                    crc_d       = crc_next;
                    cnt_d       = cnt_q + OCC_W'(1);
                    if (cnt_q == len_q - OCC_W'(1)) state_d = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                tx_byte       = ~crc_q[7:0];
                tx_byte_valid = 1'b1;
                if (xfer) state_d = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                tx_byte       = ~crc_q[15:8];
                tx_byte_valid = 1'b1;
                if (xfer) state_d = ST_EOP;
            end
            ST_EOP: begin
                tx_eop = 1'b1;
                if (tx_eop_done) state_d = ST_IDLE;
            end
            ST_ERR: begin
                TX_Error = 1'b1;
                tx_abort = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Scoreboard bench for usb_tx_pkt_ctrl: a FIFO model feeds payload bytes and the
// serializer side pops expected bytes from a queue on every valid/ready transfer.
module tb_usb_tx_pkt_ctrl;

    localparam int MAX_PAYLOAD = 64;
    localparam int OCC_W       = $clog2(MAX_PAYLOAD + 1);
    localparam int EOP_WAIT    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       tx_packet;
    logic [OCC_W-1:0] buff_occ;
    logic [7:0]       tx_data;
    logic             get_tx_data;
    logic [7:0]       tx_byte;
    logic             tx_byte_valid;
    logic             tx_byte_ready;
    logic             tx_eop;
    logic             tx_eop_done;
    logic             tx_abort;
    logic             TX_Transfer_Active;
    logic             TX_Error;

    always #5 clk = ~clk;

    usb_tx_pkt_ctrl #(.MAX_PAYLOAD(MAX_PAYLOAD), .OCC_W(OCC_W), .SYNC_BYTE(8'h80)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buff_occ           (buff_occ),
        .tx_data            (tx_data),
        .get_tx_data        (get_tx_data),
        .tx_byte            (tx_byte),
        .tx_byte_valid      (tx_byte_valid),
        .tx_byte_ready      (tx_byte_ready),
        .tx_eop             (tx_eop),
        .tx_eop_done        (tx_eop_done),
        .tx_abort           (tx_abort),
        .TX_Transfer_Active (TX_Transfer_Active),
        .TX_Error           (TX_Error)
    );

    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int pops, eop_cyc, err_cnt, abort_cnt, act_cyc, drop_at;
    bit toggle_ready, sampled_active, first_active, prev_stall, pop_pending, timed_out;
    logic [7:0] prev_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic update_fifo();
        buff_occ = OCC_W'(fifo.size());
        tx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic load_fifo(input int n, input logic [7:0] base, input bit rnd);
        fifo.delete();
        for (int i = 0; i < n; i++) fifo.push_back(rnd ? 8'($urandom) : base + 8'(i));
        update_fifo();
    endtask

    // Expected stream of a complete data packet built from the current FIFO contents.
    task automatic expect_data_pkt(input logic [7:0] pid);
        logic [15:0] c;
        c = 16'hFFFF;
        exp_q.push_back(8'h80);
        exp_q.push_back(pid);
        foreach (fifo[i]) begin
            exp_q.push_back(fifo[i]);
            c = crc_step(c, fifo[i]);
        end
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
    endtask

    // One clock: sample/score at negedge, then apply FIFO pop and next ready after posedge.
    task automatic cycle();
        logic [7:0] want;
        @(negedge clk);
        sampled_active = TX_Transfer_Active;
        if (TX_Transfer_Active) act_cyc++;
        if (TX_Error) err_cnt++;
        if (tx_abort) abort_cnt++;
        if (prev_stall) begin
            total++;
            if (tx_byte_valid !== 1'b1 || tx_byte !== prev_byte) begin
                bad++;
                $display("FAIL stall_hold got valid=%b byte=%h want valid=1 byte=%h", tx_byte_valid, tx_byte, prev_byte);
            end
        end
        if (tx_byte_valid && tx_byte_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_byte got=%h want=none", tx_byte);
            end else begin
                want = exp_q.pop_front();
                if (tx_byte !== want) begin
                    bad++;
                    $display("FAIL tx_byte got=%h want=%h", tx_byte, want);
                end
            end
        end
        prev_stall  = tx_byte_valid && !tx_byte_ready;
        prev_byte   = tx_byte;
        pop_pending = get_tx_data;
        if (get_tx_data) begin
            total++;
            if (!(tx_byte_valid && tx_byte_ready)) begin
                bad++;
                $display("FAIL pop_without_xfer got valid=%b ready=%b want both 1", tx_byte_valid, tx_byte_ready);
            end
        end
        if (tx_eop) begin
            eop_cyc++;
            total++;
            if (tx_byte_valid !== 1'b0 || tx_byte !== 8'h00) begin
                bad++;
                $display("FAIL eop_byte got valid=%b byte=%h want 0/00", tx_byte_valid, tx_byte);
            end
            if (eop_cyc == EOP_WAIT) tx_eop_done = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_eop_done = 1'b0;
        if (pop_pending) begin
            pops++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        if (drop_at > 0 && pops == drop_at) fifo.delete();
        update_fifo();
        tx_byte_ready = toggle_ready ? ~tx_byte_ready : 1'b1;
    endtask

    task automatic send(input logic [2:0] pkt, input int stop_after);
        pops = 0; eop_cyc = 0; err_cnt = 0; abort_cnt = 0; act_cyc = 0;
        prev_stall = 1'b0;
        tx_packet = pkt;
        cycle();
        tx_packet = 3'd0;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (i == 0) first_active = sampled_active;
            if (stop_after > 0 && i + 1 == stop_after) return;
            if (!sampled_active) begin
                timed_out = 1'b0;
                break;
            end
        end
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL packet_timeout got=active want=idle within 300 cycles");
        end
        cycle();
    endtask

    task automatic check_done(input string name, input int want_pops, input int want_eop,
                              input int want_err);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_bytes got=%0d left want=0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (pops != want_pops) begin
            bad++;
            $display("FAIL %s_pops got=%0d want=%0d", name, pops, want_pops);
        end
        total++;
        if (eop_cyc != want_eop) begin
            bad++;
            $display("FAIL %s_eop_cycles got=%0d want=%0d", name, eop_cyc, want_eop);
        end
        total++;
        if (err_cnt != want_err || abort_cnt != want_err) begin
            bad++;
            $display("FAIL %s_err_abort got=%0d/%0d want=%0d/%0d", name, err_cnt, abort_cnt, want_err, want_err);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({get_tx_data, tx_byte_valid, tx_eop, tx_abort, TX_Transfer_Active, TX_Error, tx_byte} !== 14'd0) begin
            bad++;
            $display("FAIL %s got get=%b v=%b eop=%b ab=%b act=%b err=%b byte=%h want all 0", name,
                     get_tx_data, tx_byte_valid, tx_eop, tx_abort, TX_Transfer_Active, TX_Error, tx_byte);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_packet = 3'd0; tx_byte_ready = 1'b1; tx_eop_done = 1'b0;
        toggle_ready = 1'b0; drop_at = 0; pop_pending = 1'b0; prev_stall = 1'b0;
        fifo.delete();
        update_fifo();
        #1;
        check_outputs_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_ack();
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hD2);
        send(3'd1, 0);
        check_done("ack", 0, EOP_WAIT, 0);
        total++;
        if (!first_active || act_cyc != 2 + EOP_WAIT) begin
            bad++;
            $display("FAIL ack_active got first=%b cycles=%0d want 1/%0d", first_active, act_cyc, 2 + EOP_WAIT);
        end
    endtask

    task automatic test_data0_check_vector();
        load_fifo(9, 8'h31, 1'b0);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'hC8);
        exp_q.push_back(8'hB4);
        send(3'd4, 0);
        check_done("data0", 9, EOP_WAIT, 0);
        total++;
        if (act_cyc != 9 + 4 + EOP_WAIT) begin
            bad++;
            $display("FAIL data0_active got=%0d want=%0d", act_cyc, 9 + 4 + EOP_WAIT);
        end
    endtask

    task automatic test_data1_empty();
        fifo.delete();
        update_fifo();
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        send(3'd5, 0);
        check_done("data1_empty", 0, EOP_WAIT, 0);
    endtask

    task automatic test_backpressure();
        load_fifo(4, 8'h00, 1'b1);
        expect_data_pkt(8'hC3);
        toggle_ready = 1'b1;
        send(3'd4, 0);
        toggle_ready  = 1'b0;
        tx_byte_ready = 1'b1;
        check_done("backpressure", 4, EOP_WAIT, 0);
    endtask

    task automatic test_back_to_back();
        load_fifo(3, 8'hE0, 1'b0);
        expect_data_pkt(8'h4B);
        send(3'd5, 0);
        check_done("b2b_data1", 3, EOP_WAIT, 0);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h1E);
        send(3'd3, 0);
        check_done("b2b_stall", 0, EOP_WAIT, 0);
    endtask

    task automatic test_underrun();
        load_fifo(4, 8'h00, 1'b1);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC3);
        exp_q.push_back(fifo[0]);
        exp_q.push_back(fifo[1]);
        drop_at = 2;
        send(3'd4, 0);
        drop_at = 0;
        check_done("underrun", 2, 0, 1);
        total++;
        if (TX_Error !== 1'b0 || TX_Transfer_Active !== 1'b0) begin
            bad++;
            $display("FAIL underrun_idle got err=%b act=%b want 0/0", TX_Error, TX_Transfer_Active);
        end
    endtask

    task automatic test_illegal();
        send(3'd6, 0);
        check_done("illegal6", 0, 0, 1);
        send(3'd7, 0);
        check_done("illegal7", 0, 0, 1);
        total++;
        if (act_cyc != 0) begin
            bad++;
            $display("FAIL illegal_active got=%0d want=0", act_cyc);
        end
        load_fifo(MAX_PAYLOAD + 1, 8'h10, 1'b0);
        send(3'd4, 0);
        check_done("oversize", 0, 0, 1);
        fifo.delete();
        update_fifo();
    endtask

    task automatic test_reset_mid_packet();
        load_fifo(8, 8'h00, 1'b1);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 3; i++) exp_q.push_back(fifo[i]);
        send(3'd4, 5);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid_outputs");
        total++;
        if (exp_q.size() != 0 || fifo.size() != 5) begin
            bad++;
            $display("FAIL reset_mid_fifo got left=%0d fifo=%0d want 0/5", exp_q.size(), fifo.size());
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pop_pending = 1'b0;
        fifo.delete();
        update_fifo();
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h5A);
        send(3'd2, 0);
        check_done("nak_after_reset", 0, EOP_WAIT, 0);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_check_vector();
        test_data1_empty();
        test_backpressure();
        test_back_to_back();
        test_underrun();
        test_illegal();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
